bus_arbiter: RTL and testbench

Sequential round-robin arbiter placed between several bus hosts (core instruction fetch, core data port, debug, DMA) and the single upstream port of the address-decoding `bus` crossbar. It replaces fixed-priority host selection with fair, transaction-level arbitration. One transaction is outstanding at a time. Each winning host owns the bus from arbitration until its response or a timeout.

---
 rtl/bus_pkg.sv | 25 ++
 rtl/bus_arbiter_rr_pick.sv | 39 +++
 rtl/bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the bus arbiter slice: FSM state encoding,
// default widths and a constant-evaluable clog2.
package bus_pkg;

    localparam int unsigned DefNrHosts        = 32'd4;
    localparam int unsigned DefDataWidth      = 32'd32;
    localparam int unsigned DefAddressWidth   = 32'd32;
    localparam int unsigned DefTimeoutCycles  = 32'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 32'd0;
        for (int unsigned i = 32'd0; i < 32'd32; i++) begin
            result = ((64'd1 << i) < 64'(value)) ? (i + 32'd1) : result;
        end
        return result;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin winner selection: first requesting index at or above rr_i,
// wrapping modulo NrHosts.
module rr_pick
    import bus_pkg::*;
#(
    parameter  int unsigned NrHosts = DefNrHosts,
    localparam int unsigned IdxW    = (NrHosts > 32'd1) ? clog2(NrHosts) : 32'd1
) (
    input  logic [NrHosts-1:0] req_i,
    input  logic [IdxW-1:0]    rr_i,
    output logic [IdxW-1:0]    winner_o,
    output logic               any_o
);

    logic [2*NrHosts-1:0] dbl_s;
    logic [NrHosts-1:0]   rot_s;
    logic [IdxW-1:0]      off_s;
    logic [IdxW:0]        sum_s;

    // Rotate so that bit 0 of rot_s is the host at the round-robin pointer.
    assign dbl_s = {req_i, req_i} >> rr_i;
    assign rot_s = dbl_s[NrHosts-1:0];

    // Lowest set bit of the rotated vector is the offset of the winner.
    always_comb begin
        off_s = '0;
        for (int i = NrHosts - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? IdxW'(i) : off_s;
        end
        sum_s = {1'b0, rr_i} + {1'b0, off_s};
        if (sum_s >= (IdxW+1)'(NrHosts)) begin
            winner_o = IdxW'(sum_s - (IdxW+1)'(NrHosts));
        end else begin
            winner_o = sum_s[IdxW-1:0];
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Transaction-level round-robin arbiter in front of the single upstream bus port;
// one transaction outstanding, owner holds the bus until response or timeout.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned NrHosts       = DefNrHosts,
    parameter int unsigned DataWidth     = DefDataWidth,
    parameter int unsigned AddressWidth  = DefAddressWidth,
    parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NrHosts-1:0]                    host_req_i,
    input  logic [NrHosts-1:0][AddressWidth-1:0]  host_addr_i,
    input  logic [NrHosts-1:0]                    host_we_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]     host_wdata_i,
    output logic [NrHosts-1:0]                    host_gnt_o,
    output logic [NrHosts-1:0]                    host_rvalid_o,
    output logic [DataWidth-1:0]                  host_rdata_o,
    output logic [NrHosts-1:0]                    host_err_o,
    output logic                                  bus_req_o,
    output logic [AddressWidth-1:0]               bus_addr_o,
    output logic                                  bus_we_o,
    output logic [DataWidth-1:0]                  bus_wdata_o,
    input  logic                                  bus_gnt_i,
    input  logic                                  bus_rvalid_i,
    input  logic [DataWidth-1:0]                  bus_rdata_i,
    input  logic                                  bus_err_i
);

    localparam int unsigned IdxW = (NrHosts > 32'd1) ? clog2(NrHosts) : 32'd1;
    localparam int unsigned CntW = clog2(TimeoutCycles + 32'd1);

    arb_state_e             state_q, state_d;
    logic [IdxW-1:0]        owner_q, owner_d;
    logic [IdxW-1:0]        rr_q, rr_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic                   we_q, we_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;

    logic [IdxW-1:0]        winner_s;
    logic                   any_s;
    logic [IdxW-1:0]        next_rr_s;
    logic [NrHosts-1:0]     owner_oh_s;

    rr_pick #(
        .NrHosts (NrHosts)
    ) u_rr_pick (
        .req_i    (host_req_i),
        .rr_i     (rr_q),
        .winner_o (winner_s),
        .any_o    (any_s)
    );

    assign bus_addr_o  = addr_q;
    assign bus_we_o    = we_q;
    assign bus_wdata_o = wdata_q;

    // Owner one-hot and the pointer value to use once the owner is done.
    always_comb begin
        owner_oh_s = {{(NrHosts-1){1'b0}}, 1'b1} << owner_q;
        if (owner_q == IdxW'(NrHosts - 32'd1)) begin
            next_rr_s = '0;
        end else begin
            next_rr_s = owner_q + IdxW'(1);
        end
    end

    // Next-state, latch updates and host/bus handshake outputs.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        bus_req_o     = 1'b0;
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;

        case (state_q)
            IDLE: begin
                if (any_s) begin
                    owner_d = winner_s;
                    addr_d  = host_addr_i[winner_s];
                    we_d    = host_we_i[winner_s];
                    wdata_d = host_wdata_i[winner_s];
                    state_d = ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                bus_req_o = 1'b1;
                if (bus_gnt_i) begin
                    host_gnt_o = owner_oh_s;
                    cnt_d      = '0;
                    state_d    = RESP;
                end else begin
                    state_d = ADDR;
                end
            end
            RESP: begin
                cnt_d = cnt_q + CntW'(1);
                // A real response on the last allowed cycle beats the timeout.
                if (bus_rvalid_i) begin
                    host_rvalid_o = owner_oh_s;
                    host_rdata_o  = bus_rdata_i;
                    host_err_o    = bus_err_i ? owner_oh_s : '0;
                    rr_d          = next_rr_s;
                    state_d       = IDLE;
                end else if (cnt_q == CntW'(TimeoutCycles - 32'd1)) begin
                    host_rvalid_o = owner_oh_s;
                    host_err_o    = owner_oh_s;
                    rr_d          = next_rr_s;
                    state_d       = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, ownership, pointer, timeout counter and latched request fields.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected host grant/response events are
// queued with their cycle stamp when stimulus is driven and matched by a monitor.
module tb_bus_arbiter;

    localparam int NH = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [NH-1:0]        host_req_i;
    logic [NH-1:0][AW-1:0] host_addr_i;
    logic [NH-1:0]        host_we_i;
    logic [NH-1:0][DW-1:0] host_wdata_i;
    logic [NH-1:0]        host_gnt_o;
    logic [NH-1:0]        host_rvalid_o;
    logic [DW-1:0]        host_rdata_o;
    logic [NH-1:0]        host_err_o;
    logic                 bus_req_o;
    logic [AW-1:0]        bus_addr_o;
    logic                 bus_we_o;
    logic [DW-1:0]        bus_wdata_o;
    logic                 bus_gnt_i;
    logic                 bus_rvalid_i;
    logic [DW-1:0]        bus_rdata_i;
    logic                 bus_err_i;

    typedef struct {
        int            cyc;
        logic [NH-1:0] gnt;
        logic [NH-1:0] rv;
        logic [DW-1:0] rdata;
        logic [NH-1:0] err;
    } ev_t;

    ev_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc   = 0;

    bus_arbiter #(
        .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .host_req_i(host_req_i), .host_addr_i(host_addr_i),
        .host_we_i(host_we_i), .host_wdata_i(host_wdata_i),
        .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
        .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
        .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o),
        .bus_we_o(bus_we_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [NH-1:0] g, input logic [NH-1:0] r,
                        input logic [DW-1:0] d, input logic [NH-1:0] e);
        ev_t ev;
        ev.cyc = c; ev.gnt = g; ev.rv = r; ev.rdata = d; ev.err = e;
        sb_q.push_back(ev);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: match host-side events against the scoreboard mid-cycle.
    always @(negedge clk_i) begin
        ev_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            chk("missed_event_cyc", 64'(cyc), 64'(sb_q[0].cyc));
            void'(sb_q.pop_front());
        end
        if (host_gnt_o != '0 || host_rvalid_o != '0) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_event", 64'({host_gnt_o, host_rvalid_o}), 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("ev_cyc",    64'(cyc),           64'(e.cyc));
                chk("ev_gnt",    64'(host_gnt_o),    64'(e.gnt));
                chk("ev_rvalid", 64'(host_rvalid_o), 64'(e.rv));
                chk("ev_rdata",  64'(host_rdata_o),  64'(e.rdata));
                chk("ev_err",    64'(host_err_o),    64'(e.err));
            end
        end else begin
            chk("quiet_outs", 64'({host_rdata_o, host_err_o}), 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        rst_ni       = 1'b0;
        host_req_i   = 4'b1111;
        host_addr_i  = '0;
        host_we_i    = 4'b0000;
        host_wdata_i = '0;
        bus_gnt_i    = 1'b1;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = 32'h0;
        bus_err_i    = 1'b0;

        // Reset holds everything quiet even with requests pending.
        step(); step();
        chk("rst_bus_req",  64'(bus_req_o),  64'd0);
        chk("rst_bus_addr", 64'(bus_addr_o), 64'd0);
        chk("rst_host_gnt", 64'(host_gnt_o), 64'd0);
        host_req_i = 4'b0000;
        rst_ni     = 1'b1;
        step();
        chk("post_rst_bus_req", 64'(bus_req_o), 64'd0);

        // Fairness: all hosts request, immediate gnt/rvalid.
        for (int h = 0; h < NH; h++) host_addr_i[h] = 32'(h * 256);
        bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0000_00A5;
        c = cyc;
        host_req_i = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            push(c + 3*k + 1, 4'b0001 << (k % 4), 4'b0000, 32'h0, 4'b0000);
            push(c + 3*k + 2, 4'b0000, 4'b0001 << (k % 4), 32'h0000_00A5, 4'b0000);
        end
        for (int i = 1; i <= 18; i++) begin
            step();
            if (i % 3 == 1) chk("fair_addr", 64'(bus_addr_o), 64'(((i / 3) % 4) * 256));
        end
        host_req_i = 4'b0000;
        step();

        // Single read by host 1.
        c = cyc;
        host_req_i = 4'b0010; host_addr_i[1] = 32'h0000_1000; host_we_i = 4'b0000;
        bus_rdata_i = 32'hDEAD_BEEF;
        push(c + 1, 4'b0010, 4'b0000, 32'h0, 4'b0000);
        push(c + 2, 4'b0000, 4'b0010, 32'hDEAD_BEEF, 4'b0000);
        step();
        chk("rd_bus_req",  64'(bus_req_o),  64'd1);
        chk("rd_bus_addr", 64'(bus_addr_o), 64'h1000);
        chk("rd_bus_we",   64'(bus_we_o),   64'd0);
        step(); host_req_i = 4'b0000;
        step();

        // Stall: host 2 write, bus grant withheld for 5 cycles.
        c = cyc;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        host_req_i = 4'b0100; host_addr_i[2] = 32'h2000_0010;
        host_we_i = 4'b0100; host_wdata_i[2] = 32'hCAFE_0000;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("stall_req",   64'(bus_req_o),   64'd1);
            chk("stall_addr",  64'(bus_addr_o),  64'h2000_0010);
            chk("stall_we",    64'(bus_we_o),    64'd1);
            chk("stall_wdata", 64'(bus_wdata_o), 64'hCAFE_0000);
        end
        step();
        bus_gnt_i = 1'b1;
        push(c + 6, 4'b0100, 4'b0000, 32'h0, 4'b0000);
        step();
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0000_0001;
        host_req_i = 4'b0000;
        push(c + 7, 4'b0000, 4'b0100, 32'h0000_0001, 4'b0000);
        step();
        bus_rvalid_i = 1'b0; host_we_i = 4'b0000;

        // Timeout: host 0, no response; a late rvalid is ignored.
        c = cyc;
        host_req_i = 4'b0001; host_addr_i[0] = 32'h0000_3000;
        bus_gnt_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
        push(c + 1, 4'b0001, 4'b0000, 32'h0, 4'b0000);
        push(c + 1 + TO, 4'b0000, 4'b0001, 32'h0, 4'b0001);
        step(); step();
        host_req_i = 4'b0000;
        repeat (17) step();
        bus_rvalid_i = 1'b1;
        step();
        bus_rvalid_i = 1'b0;

        // Response arriving on the final allowed cycle wins over the timeout.
        c = cyc;
        host_req_i = 4'b0010; bus_rdata_i = 32'h5A5A_5A5A;
        push(c + 1, 4'b0010, 4'b0000, 32'h0, 4'b0000);
        push(c + 1 + TO, 4'b0000, 4'b0010, 32'h5A5A_5A5A, 4'b0000);
        step(); step();
        host_req_i = 4'b0000;
        repeat (15) step();
        bus_rvalid_i = 1'b1;
        step();
        bus_rvalid_i = 1'b0;

        // Bus error to host 2, then pointer sits at 3: host 3 beats host 2.
        c = cyc;
        host_req_i = 4'b0100; bus_rvalid_i = 1'b1; bus_err_i = 1'b1;
        bus_rdata_i = 32'h0BAD_0BAD;
        push(c + 1, 4'b0100, 4'b0000, 32'h0, 4'b0000);
        push(c + 2, 4'b0000, 4'b0100, 32'h0BAD_0BAD, 4'b0100);
        step(); step();
        host_req_i = 4'b0000;
        step();
        bus_err_i = 1'b0;
        c = cyc;
        host_req_i = 4'b1100;
        push(c + 1, 4'b1000, 4'b0000, 32'h0, 4'b0000);
        push(c + 2, 4'b0000, 4'b1000, 32'h0BAD_0BAD, 4'b0000);
        push(c + 4, 4'b0100, 4'b0000, 32'h0, 4'b0000);
        push(c + 5, 4'b0000, 4'b0100, 32'h0BAD_0BAD, 4'b0000);
        step(); step();
        host_req_i = 4'b0100;
        step(); step(); step();
        host_req_i = 4'b0000;
        step();

        // Reset while host 3 is in its response phase.
        c = cyc;
        host_req_i = 4'b1000; host_addr_i[3] = 32'h4000_0040;
        bus_gnt_i = 1'b1; bus_rvalid_i = 1'b0;
        push(c + 1, 4'b1000, 4'b0000, 32'h0, 4'b0000);
        step(); step();
        host_req_i = 4'b0000;
        step();
        rst_ni = 1'b0; bus_rvalid_i = 1'b1;
        #1;
        chk("mid_rst_bus_req",  64'(bus_req_o),     64'd0);
        chk("mid_rst_bus_addr", 64'(bus_addr_o),    64'd0);
        chk("mid_rst_rvalid",   64'(host_rvalid_o), 64'd0);
        step();
        rst_ni = 1'b1;
        step();
        chk("post_rst2_bus_req", 64'(bus_req_o), 64'd0);
        c = cyc;
        host_req_i = 4'b1001; host_addr_i[0] = 32'h0000_5000;
        bus_rdata_i = 32'h600D_600D;
        push(c + 1, 4'b0001, 4'b0000, 32'h0, 4'b0000);
        push(c + 2, 4'b0000, 4'b0001, 32'h600D_600D, 4'b0000);
        push(c + 4, 4'b1000, 4'b0000, 32'h0, 4'b0000);
        push(c + 5, 4'b0000, 4'b1000, 32'h600D_600D, 4'b0000);
        step(); step();
        host_req_i = 4'b1000;
        step(); step(); step();
        host_req_i = 4'b0000;
        step(); step();

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
